// File: rtl/wb_reg_responder.sv
// Wishbone slave endpoint: a bank of 32-bit registers with byte-select writes,
// a read-only ID word at index 0 and a registered ack/err after WAIT_CYCLES wait states.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for cyc&stb; request fields are captured here
//   S_WAIT | counting wait states; dropping cyc aborts back to S_IDLE
//   S_RESP | one-cycle ack or err pulse; a good write commits at its end
//   S_TURN | one quiet cycle that swallows the upstream stage's held stb
module wb_reg_responder #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5EC0_0001
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic                   wbs_we_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic [1:0]             wbs_tid_i,
    output logic [31:0]            wbs_dat_o,
    output logic                   wbs_ack_o,
    output logic                   wbs_err_o,
    output logic [1:0]             wbs_tid_o,
    output logic [NUM_REGS*32-1:0] reg_q_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_TURN} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q;
    logic [9:0]  idx_q;
    logic [31:0] wdat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [1:0]  tid_cap_q;
    logic [3:0]  cnt_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] dat_q;
    logic [1:0]  tid_q;
    logic [31:0] regs_q [1:NUM_REGS-1];

    logic [9:0]  src_idx;
    logic        src_we;
    logic [1:0]  src_tid;
    logic        resp_err;
    logic [31:0] src_rdata;
    logic [31:0] resp_dat;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^{wbs_adr_i[31:12], wbs_adr_i[1:0]};

    // With zero wait states the response is formed from the live request in
    // the same edge that captures it, so the source muxes between bus and capture.
    always_comb begin
        src_idx   = (state_q == S_IDLE) ? wbs_adr_i[11:2] : idx_q;
        src_we    = (state_q == S_IDLE) ? wbs_we_i        : we_q;
        src_tid   = (state_q == S_IDLE) ? wbs_tid_i       : tid_cap_q;
        resp_err  = ({1'b0, src_idx} >= 11'(NUM_REGS)) || (src_we && (src_idx == 10'd0));
        src_rdata = (src_idx == 10'd0) ? ID_VALUE : 32'd0;
        for (int k = 1; k < NUM_REGS; k++) begin
            if ({1'b0, src_idx} == 11'(k)) src_rdata = regs_q[k];
        end
        resp_dat  = (!resp_err && !src_we) ? src_rdata : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            tid_cap_q <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            tid_q     <= '0;
            for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            tid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        idx_q     <= wbs_adr_i[11:2];
                        wdat_q    <= wbs_dat_i;
                        sel_q     <= wbs_sel_i;
                        we_q      <= wbs_we_i;
                        tid_cap_q <= wbs_tid_i;
                        cnt_q     <= CNT_INIT;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                            ack_q   <= !resp_err;
                            err_q   <= resp_err;
                            dat_q   <= resp_dat;
                            tid_q   <= src_tid;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= S_RESP;
                            ack_q   <= !resp_err;
                            err_q   <= resp_err;
                            dat_q   <= resp_dat;
                            tid_q   <= src_tid;
                        end
                    end
                end
                S_RESP: begin
                    if (ack_q && we_q) begin
                        for (int k = 1; k < NUM_REGS; k++) begin
                            if ({1'b0, idx_q} == 11'(k)) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (sel_q[b]) regs_q[k][8*b +: 8] <= wdat_q[8*b +: 8];
                                end
                            end
                        end
                    end
                    state_q <= S_TURN;
                end
                S_TURN:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbs_dat_o = dat_q;
    assign wbs_tid_o = tid_q;

    assign reg_q_o[31:0] = ID_VALUE;
    for (genvar k = 1; k < NUM_REGS; k++) begin : g_flat
        assign reg_q_o[32*k +: 32] = regs_q[k];
    end

endmodule

// File: tb/tb_wb_reg_responder.sv
// Directed bench for wb_reg_responder: four instances with 0/1/3/15 wait states,
// expected responses queued at request time and checked when ack/err appears.
module tb_wb_reg_responder;

    localparam logic [31:0] ID = 32'h5EC0_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  dat_i [4];
    logic [31:0]  adr_i [4];
    logic [3:0]   sel_i [4];
    logic         we_i  [4];
    logic         cyc_i [4];
    logic         stb_i [4];
    logic [1:0]   tid_i [4];
    logic [31:0]  dat_o [4];
    logic         ack_o [4];
    logic         err_o [4];
    logic [1:0]   tid_o [4];
    logic [511:0] regq  [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_reg_responder #(
            .NUM_REGS   (16),
            .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15),
            .ID_VALUE   (ID)
        ) u_dut (
            .clk_i    (clk),
            .rst_n    (rst_n),
            .wbs_dat_i(dat_i[g]),
            .wbs_adr_i(adr_i[g]),
            .wbs_sel_i(sel_i[g]),
            .wbs_we_i (we_i[g]),
            .wbs_cyc_i(cyc_i[g]),
            .wbs_stb_i(stb_i[g]),
            .wbs_tid_i(tid_i[g]),
            .wbs_dat_o(dat_o[g]),
            .wbs_ack_o(ack_o[g]),
            .wbs_err_o(err_o[g]),
            .wbs_tid_o(tid_o[g]),
            .reg_q_o  (regq[g])
        );
    end

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic [1:0]  tid;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [4][16];
    int          total = 0;
    int          bad = 0;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : (d == 2) ? 3 : 15;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input int d);
        for (int k = 0; k < 16; k++)
            check($sformatf("d%0d_reg%0d", d, k), 64'(regq[d][32*k +: 32]), 64'(model[d][k]));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            model[d][0] = ID;
            for (int k = 1; k < 16; k++) model[d][k] = '0;
        end
    endtask

    task automatic count_extra(input int d, input string tag);
        int extra = 0;
        repeat (18) begin
            @(negedge clk);
            if (ack_o[d] || err_o[d]) extra++;
        end
        check(tag, 64'(extra), 64'd0);
    endtask

    task automatic xact(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [1:0] tid);
        exp_t e;
        exp_t got;
        int   idx;
        int   lat;
        bit   seen;
        idx   = int'(adr[11:2]);
        e.err = (idx >= 16) || (we && idx == 0);
        e.ack = !e.err;
        e.dat = (!e.err && !we) ? model[d][idx] : 32'd0;
        e.tid = tid;
        e.lat = wait_of(d);
        sb.push_back(e);
        if (!e.err && we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[d][idx][8*b +: 8] = dat[8*b +: 8];

        @(negedge clk);
        adr_i[d] = adr; dat_i[d] = dat; sel_i[d] = sel; we_i[d] = we; tid_i[d] = tid;
        cyc_i[d] = 1'b1; stb_i[d] = 1'b1;
        @(posedge clk);
        #1;
        adr_i[d] = 32'hFFFF_FFFC; dat_i[d] = ~dat; sel_i[d] = ~sel; we_i[d] = ~we; tid_i[d] = ~tid;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_o[d] || err_o[d]) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            @(posedge clk);
        end
        got = sb.pop_front();
        if (!seen) begin
            check($sformatf("d%0d_timeout", d), 64'd0, 64'd1);
        end else begin
            check($sformatf("d%0d_ack", d), 64'(ack_o[d]), 64'(got.ack));
            check($sformatf("d%0d_err", d), 64'(err_o[d]), 64'(got.err));
            check($sformatf("d%0d_dat", d), 64'(dat_o[d]), 64'(got.dat));
            check($sformatf("d%0d_tid", d), 64'(tid_o[d]), 64'(got.tid));
            check($sformatf("d%0d_lat", d), 64'(lat), 64'(got.lat));
            check($sformatf("d%0d_excl", d), 64'(ack_o[d] & err_o[d]), 64'd0);
        end
        @(negedge clk);
        check($sformatf("d%0d_turn_ack", d), 64'(ack_o[d]), 64'd0);
        check($sformatf("d%0d_turn_err", d), 64'(err_o[d]), 64'd0);
        check($sformatf("d%0d_turn_dat", d), 64'(dat_o[d]), 64'd0);
        check_bank(d);
        @(negedge clk);
        cyc_i[d] = 1'b0; stb_i[d] = 1'b0;
        count_extra(d, $sformatf("d%0d_extra_pulse", d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            dat_i[d] = '0; adr_i[d] = '0; sel_i[d] = '0; we_i[d] = 1'b0;
            cyc_i[d] = 1'b1; stb_i[d] = 1'b1; tid_i[d] = 2'd3;
        end
        model_reset();

        // reset held with a live request on the bus
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_d%0d_ack", d), 64'(ack_o[d]), 64'd0);
            check($sformatf("rst_d%0d_err", d), 64'(err_o[d]), 64'd0);
            check($sformatf("rst_d%0d_dat", d), 64'(dat_o[d]), 64'd0);
            check($sformatf("rst_d%0d_tid", d), 64'(tid_o[d]), 64'd0);
        end
        check_bank(1);
        for (int d = 0; d < 4; d++) begin
            cyc_i[d] = 1'b0; stb_i[d] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // byte-select writes and reads, one wait state
        xact(1, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b1111, 2'd2);
        xact(1, 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 2'd1);
        check("reg2_bytesel", 64'(regq[1][95:64]), 64'h0000_0000_AA22_CC44);
        xact(1, 1'b0, 32'h8, 32'h0, 4'b0000, 2'd3);
        xact(1, 1'b0, 32'h0, 32'h0, 4'b1111, 2'd0);
        xact(1, 1'b1, 32'h1234_5007, 32'h0102_0304, 4'b1010, 2'd1);
        xact(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 2'd2);
        xact(1, 1'b0, 32'h4, 32'h0, 4'b0001, 2'd2);

        // error paths
        xact(1, 1'b0, 32'h40, 32'h0, 4'b1111, 2'd0);
        xact(1, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'b1111, 2'd1);
        check("id_word_kept", 64'(regq[1][31:0]), 64'(ID));
        xact(1, 1'b1, 32'hFFC, 32'h5555_5555, 4'b1111, 2'd3);

        // wait-state sweep
        xact(0, 1'b1, 32'h4, 32'h0BAD_F00D, 4'b1111, 2'd1);
        xact(0, 1'b0, 32'h4, 32'h0, 4'b1111, 2'd2);
        xact(2, 1'b1, 32'h4, 32'h7777_8888, 4'b1100, 2'd3);
        xact(2, 1'b0, 32'h4, 32'h0, 4'b1111, 2'd0);
        xact(3, 1'b1, 32'h3C, 32'h9999_AAAA, 4'b0011, 2'd2);
        xact(3, 1'b0, 32'h3C, 32'h0, 4'b1111, 2'd1);

        // abort: drop cyc in the second wait cycle
        @(negedge clk);
        adr_i[2] = 32'h4; dat_i[2] = 32'hCAFE_F00D; sel_i[2] = 4'hF; we_i[2] = 1'b1; tid_i[2] = 2'd1;
        cyc_i[2] = 1'b1; stb_i[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc_i[2] = 1'b0; stb_i[2] = 1'b0;
        count_extra(2, "abort_no_resp");
        check("abort_reg1", 64'(regq[2][63:32]), 64'h0000_0000_7777_0000);
        xact(2, 1'b0, 32'h4, 32'h0, 4'b1111, 2'd3);

        // reset during the response cycle of a write
        @(negedge clk);
        adr_i[1] = 32'hC; dat_i[1] = 32'h1234_5678; sel_i[1] = 4'hF; we_i[1] = 1'b1; tid_i[1] = 2'd1;
        cyc_i[1] = 1'b1; stb_i[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midrst_ack_before", 64'(ack_o[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ack_drop", 64'(ack_o[1]), 64'd0);
        cyc_i[1] = 1'b0; stb_i[1] = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_reg3", 64'(regq[1][127:96]), 64'd0);
        check_bank(1);
        repeat (2) @(negedge clk);
        xact(1, 1'b0, 32'hC, 32'h0, 4'b1111, 2'd2);
        xact(1, 1'b0, 32'h8, 32'h0, 4'b1111, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
